// File: rtl/cross_bar_pkg.sv
// rtl/cross_bar_pkg.sv - shared crossbar sizing constants
package cross_bar_pkg;
  localparam int MASTER_N = 2;
endpackage

// File: rtl/cross_bar_resp_router_if.sv
// rtl/cross_bar_resp_router_if.sv - grant/ack/response bundle between arbiter, slave and masters
interface cross_bar_resp_router_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int MASTER_N = cross_bar_pkg::MASTER_N;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic [MASTER_N-1:0]        grant;
  logic                       slave_ack;
  logic                       slave_rd;
  logic                       slave_resp;
  logic [DATA_W-1:0]          slave_rdata;
  logic [MASTER_N-1:0]        master_resp;
  logic [MASTER_N*DATA_W-1:0] master_rdata;
  logic                       full;
  logic [CNT_W-1:0]           outstanding;
  logic                       err;

  modport master (
    output grant, slave_ack, slave_rd, slave_resp, slave_rdata,
    input  master_resp, master_rdata, full, outstanding, err
  );

  modport slave (
    input  grant, slave_ack, slave_rd, slave_resp, slave_rdata,
    output master_resp, master_rdata, full, outstanding, err
  );
endinterface

// File: rtl/cross_bar_resp_router.sv
// rtl/cross_bar_resp_router.sv - in-order read-response router for one slave port
// Accepted reads queue their master index; each slave response pops the head and is steered there.
module cross_bar_resp_router #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cross_bar_resp_router_if.slave  bus
);
  localparam int MASTER_N = cross_bar_pkg::MASTER_N;
  localparam int IDX_W    = $clog2(MASTER_N);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);

  logic [IDX_W-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]           wptr;
  logic [PTR_W-1:0]           rptr;
  logic [CNT_W-1:0]           count;
  logic                       err_r;
  logic [MASTER_N-1:0]        resp_r;
  logic [MASTER_N*DATA_W-1:0] rdata_r;

  logic             grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] head_idx;
  logic             full_w;
  logic             empty_w;
  logic             rd_ack;
  logic             push;
  logic             pop;
  logic             err_evt;

  always_comb begin
    grant_idx = '0;
    for (int m = 0; m < MASTER_N; m++) begin
      if (bus.grant[m]) grant_idx = IDX_W'(m);
    end
  end

  assign grant_onehot = (bus.grant != '0) &&
                        ((bus.grant & (bus.grant - MASTER_N'(1))) == '0);
  // full is decoded from the registered count only, so the arbiter sees no input-to-full path
  assign full_w   = (count == CNT_W'(DEPTH));
  assign empty_w  = (count == '0);
  assign rd_ack   = bus.slave_ack & bus.slave_rd;
  assign push     = rd_ack & ~full_w & grant_onehot;
  assign pop      = bus.slave_resp & ~empty_w;
  assign err_evt  = (bus.slave_resp & empty_w) | (rd_ack & full_w) | (rd_ack & ~grant_onehot);
  assign head_idx = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      err_r   <= 1'b0;
      resp_r  <= '0;
      rdata_r <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (err_evt) err_r <= 1'b1;
      resp_r  <= '0;
      rdata_r <= '0;
      if (pop) begin
        resp_r[head_idx]                    <= 1'b1;
        rdata_r[head_idx*DATA_W +: DATA_W]  <= bus.slave_rdata;
      end
    end
  end

  assign bus.master_resp  = resp_r;
  assign bus.master_rdata = rdata_r;
  assign bus.full         = full_w;
  assign bus.outstanding  = count;
  assign bus.err          = err_r;
endmodule

// File: tb/tb_cross_bar_resp_router.sv
// tb/tb_cross_bar_resp_router.sv - randomized self-checking bench with a queue-based reference model
module tb_cross_bar_resp_router;
  localparam int MASTER_N = cross_bar_pkg::MASTER_N;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int VW       = MASTER_N + MASTER_N*DATA_W + CNT_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cross_bar_resp_router_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  cross_bar_resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of master indices in accept order plus expected registered outputs
  int                         q[$];
  logic [MASTER_N-1:0]        exp_resp;
  logic [MASTER_N*DATA_W-1:0] exp_rdata;
  logic                       exp_err;

  function automatic logic [VW-1:0] observed();
    return {bus.master_resp, bus.master_rdata, bus.outstanding, bus.full, bus.err};
  endfunction

  function automatic logic [VW-1:0] expected();
    return {exp_resp, exp_rdata, CNT_W'(q.size()), (q.size() == DEPTH), exp_err};
  endfunction

  task automatic idle_inputs();
    bus.grant = '0; bus.slave_ack = 0; bus.slave_rd = 0; bus.slave_resp = 0; bus.slave_rdata = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    q.delete();
    exp_resp = '0; exp_rdata = '0; exp_err = 1'b0;
  endtask

  task automatic drive(input logic [MASTER_N-1:0] g, input logic a, input logic rd,
                       input logic rs, input logic [DATA_W-1:0] d);
    bit was_full, was_empty, ok_grant;
    int idx, m;
    bus.grant = g; bus.slave_ack = a; bus.slave_rd = rd; bus.slave_resp = rs; bus.slave_rdata = d;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    ok_grant  = ($countones(g) == 1);
    idx = 0;
    for (int k = 0; k < MASTER_N; k++) if (g[k]) idx = k;
    exp_resp = '0; exp_rdata = '0;
    if (rs && was_empty) exp_err = 1'b1;
    if (a && rd && (was_full || !ok_grant)) exp_err = 1'b1;
    if (rs && !was_empty) begin
      m = q.pop_front();
      exp_resp[m] = 1'b1;
      exp_rdata[m*DATA_W +: DATA_W] = d;
    end
    if (a && rd && !was_full && ok_grant) q.push_back(idx);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== '0) begin
        errors++; $display("FAIL reset_hold cyc%0d got=%h exp=0", i, observed());
      end
    end
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      drive('0, 0, 0, 0, '0);
      checks++;
      if (observed() !== '0) begin
        errors++; $display("FAIL reset_idle cyc%0d got=%h exp=0", i, observed());
      end
    end
  endtask

  task automatic test_single_read();
    drive(2'b10, 1, 1, 0, '0);
    checks++;
    if (bus.outstanding !== CNT_W'(1)) begin
      errors++; $display("FAIL single_push outstanding got=%0d exp=1", bus.outstanding);
    end
    drive('0, 0, 0, 0, '0);
    drive('0, 0, 0, 0, '0);
    drive('0, 0, 0, 1, 32'hCAFE0001);
    checks++;
    if ({bus.master_resp, bus.master_rdata, bus.outstanding} !== {2'b10, 32'hCAFE0001, 32'h0, 3'd0}) begin
      errors++; $display("FAIL single_resp got=%b %h %0d exp=10 cafe000100000000 0",
                         bus.master_resp, bus.master_rdata, bus.outstanding);
    end
    drive('0, 0, 0, 0, '0);
    checks++;
    if (observed() !== expected()) begin
      errors++; $display("FAIL single_after got=%h exp=%h", observed(), expected());
    end
  endtask

  task automatic test_order_wrap();
    int ms[6]   = '{0, 1, 1, 0, 1, 0};
    int ops[12] = '{1, 1, 1, 1, 2, 1, 2, 1, 2, 2, 2, 2};
    int p = 0, k = 0;
    logic [MASTER_N-1:0] g, want;
    for (int i = 0; i < 12; i++) begin
      if (ops[i] == 1) begin
        g = '0; g[ms[p]] = 1'b1; p++;
        drive(g, 1, 1, 0, '0);
      end else begin
        drive('0, 0, 0, 1, $urandom);
        want = '0; want[ms[k]] = 1'b1; k++;
        checks++;
        if (bus.master_resp !== want) begin
          errors++; $display("FAIL order_resp%0d got=%b exp=%b", k - 1, bus.master_resp, want);
        end
      end
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL order_model step%0d got=%h exp=%h", i, observed(), expected());
      end
      if (i == 3) begin
        checks++;
        if (bus.full !== 1'b1) begin
          errors++; $display("FAIL order_full got=%b exp=1", bus.full);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    drive(2'b10, 1, 1, 0, '0);
    drive(2'b10, 1, 1, 0, '0);
    drive(2'b01, 1, 1, 1, 32'h1234_5678);
    checks++;
    if ({bus.master_resp, bus.outstanding} !== {2'b10, 3'd2}) begin
      errors++; $display("FAIL pushpop got=%b/%0d exp=10/2", bus.master_resp, bus.outstanding);
    end
    for (int i = 0; i < 3; i++) begin
      drive('0, 0, 0, 1, $urandom);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL pushpop_drain%0d got=%h exp=%h", i, observed(), expected());
      end
    end
    checks++;
    if (exp_err !== 1'b1 || bus.err !== 1'b1) begin
      errors++; $display("FAIL pushpop_extra_err got=%b exp=1", bus.err);
    end
  endtask

  task automatic test_errors();
    do_reset(1);
    drive('0, 0, 0, 1, 32'hDEAD0000);
    drive('0, 0, 0, 0, '0);
    checks++;
    if ({bus.err, bus.master_resp, bus.outstanding} !== {1'b1, 2'b00, 3'd0}) begin
      errors++; $display("FAIL err_empty got=%b/%b/%0d exp=1/00/0", bus.err, bus.master_resp, bus.outstanding);
    end
    do_reset(1);
    for (int i = 0; i < 4; i++) drive(2'(1 << (i % 2)), 1, 1, 0, '0);
    drive(2'b01, 1, 1, 0, '0);
    checks++;
    if ({bus.err, bus.outstanding, bus.full} !== {1'b1, 3'd4, 1'b1}) begin
      errors++; $display("FAIL err_full got=%b/%0d/%b exp=1/4/1", bus.err, bus.outstanding, bus.full);
    end
    drive('0, 0, 0, 1, 32'h5);
    checks++;
    if (observed() !== expected()) begin
      errors++; $display("FAIL err_full_pop got=%h exp=%h", observed(), expected());
    end
    do_reset(1);
    drive(2'b11, 1, 1, 0, '0);
    checks++;
    if ({bus.err, bus.outstanding} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL err_grant11 got=%b/%0d exp=1/0", bus.err, bus.outstanding);
    end
    do_reset(1);
    drive(2'b00, 1, 1, 0, '0);
    drive(2'b01, 1, 0, 0, '0);
    checks++;
    if ({bus.err, bus.outstanding} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL err_grant00 got=%b/%0d exp=1/0", bus.err, bus.outstanding);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(1);
    for (int i = 0; i < 3; i++) drive(2'b10, 1, 1, 0, '0);
    do_reset(1);
    checks++;
    if ({bus.outstanding, bus.err} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL midrst got=%0d/%b exp=0/0", bus.outstanding, bus.err);
    end
    drive('0, 0, 0, 1, 32'hBEEF);
    checks++;
    if ({bus.master_resp, bus.err} !== {2'b00, 1'b1}) begin
      errors++; $display("FAIL midrst_resp got=%b/%b exp=00/1", bus.master_resp, bus.err);
    end
  endtask

  task automatic test_random();
    logic [MASTER_N-1:0] g;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset(1);
      if ($urandom_range(0, 9) < 8) begin
        g = '0; g[$urandom_range(0, MASTER_N - 1)] = 1'b1;
      end else begin
        g = MASTER_N'($urandom_range(0, 1) != 0 ? {MASTER_N{1'b1}} : '0);
      end
      drive(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), $urandom);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random cyc%0d got=%h exp=%h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    q.delete();
    exp_resp = '0; exp_rdata = '0; exp_err = 1'b0;
    test_reset();
    test_single_read();
    test_order_wrap();
    test_push_pop();
    test_errors();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
